// File: rtl/reg_file_read.sv
// Register file with a two-operand registered read port, single write port and a
// sequential clear engine. Define REG_FILE_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_read #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int AW     = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [AW-1:0]     WADDR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              RD_REQ,
    input  logic [AW-1:0]     RADDR1,
    input  logic [AW-1:0]     RADDR2,
    output logic              RD_READY,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] R1_out,
    output logic [DATA_W-1:0] R2_out,
    input  logic              CLR_REQ,
    output logic              BUSY
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [AW-1:0]     ptr_r;
    logic [AW-1:0]     ptr_s;
    logic [DATA_W-1:0] regs_r [NREG];
    logic              rd_fire_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] rdata1_s;
    logic [DATA_W-1:0] rdata2_s;
    logic              rd_valid_r;
    logic [DATA_W-1:0] r1_r;
    logic [DATA_W-1:0] r2_r;

    // Next-state and clear-pointer logic; CLR_REQ only matters in IDLE so a clear never restarts.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (CLR_REQ) begin
                    state_s = CLEAR;
                    ptr_s   = {AW{1'b0}};
                end else begin
                    state_s = IDLE;
                    ptr_s   = ptr_r;
                end
            end
            CLEAR: begin
                ptr_s = ptr_r + AW'(1'b1);
                if (ptr_r == AW'(NREG - 1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            default: begin
                state_s = IDLE;
                ptr_s   = {AW{1'b0}};
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            ptr_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    assign rd_fire_s = RD_REQ && (state_r == IDLE);
    assign wr_en_s   = WE && (state_r == IDLE);

    // Operand selection, optionally forwarding the write being committed on this edge.
    always_comb begin
        rdata1_s = regs_r[RADDR1];
        rdata2_s = regs_r[RADDR2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en_s && (WADDR == RADDR1)) begin
            rdata1_s = WDATA;
        end else begin
            rdata1_s = regs_r[RADDR1];
        end
        if (wr_en_s && (WADDR == RADDR2)) begin
            rdata2_s = WDATA;
        end else begin
            rdata2_s = regs_r[RADDR2];
        end
`else
        rdata1_s = regs_r[RADDR1];
        rdata2_s = regs_r[RADDR2];
`endif
    end

    // Register array: clear target wins over writes, which are only accepted in IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (state_r == CLEAR) begin
            regs_r[ptr_r] <= {DATA_W{1'b0}};
        end else if (wr_en_s) begin
            regs_r[WADDR] <= WDATA;
        end
    end

    // Read output registers: data holds between completed reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_valid_r <= 1'b0;
            r1_r       <= {DATA_W{1'b0}};
            r2_r       <= {DATA_W{1'b0}};
        end else if (rd_fire_s) begin
            rd_valid_r <= 1'b1;
            r1_r       <= rdata1_s;
            r2_r       <= rdata2_s;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign BUSY     = (state_r == CLEAR);
    assign RD_READY = (state_r == IDLE);
    assign RD_VALID = rd_valid_r;
    assign R1_out   = r1_r;
    assign R2_out   = r2_r;

endmodule
